uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The parameter SHALL be: BAUD_W, default 19, width of the baud divisor input k.
REQ-002 The port clk SHALL be: input, 1 bit, system clock (100 MHz); the block has exactly one clock.
REQ-003 The port reset SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 The port load SHALL be: input, 1 bit, single-cycle request to transmit out_port.
REQ-005 The port out_port SHALL be: input, 8 bits, byte to transmit.
REQ-006 The port k SHALL be: input, BAUD_W bits, clocks per bit time.
REQ-007 The port eight SHALL be: input, 1 bit; 1 = 8 data bits, 0 = 7 data bits.
REQ-008 The port pen SHALL be: input, 1 bit, parity enable.
REQ-009 The port ohel SHALL be: input, 1 bit, parity select; 1 = odd, 0 = even.
REQ-010 The port tx SHALL be: output, 1 bit, serial line, idle high.
REQ-011 The port txrdy SHALL be: output, 1 bit; high = ready to accept load.

Function
REQ-012 The block SHALL have two states: IDLE (txrdy=1, tx=1) and SHIFT (txrdy=0).
REQ-013 In IDLE, load=1 SHALL latch out_port, eight, pen and ohel into an 11-bit frame register, enter SHIFT, and drive txrdy=0 on the next clock.
REQ-014 load while in SHIFT SHALL be ignored, with no latch and no effect on the frame in progress.
REQ-015 The frame SHALL always be 11 bit-times, bit 0 first: start=0, then D0..D6, then the following positions:
- {D7, parity, 1} for eight=1, pen=1
- {D7, 1, 1} for eight=1, pen=0
- {parity, 1, 1} for eight=0, pen=1
- {1, 1, 1} for eight=0, pen=0
REQ-016 Parity SHALL be computed over the transmitted data bits only: XOR of D0..D6 (plus D7 when eight=1), inverted when ohel=1.
REQ-017 tx SHALL go low (start bit) on the first clock after load is accepted.
REQ-018 Each bit SHALL be held exactly max(k,1) clocks; k=0 SHALL behave as k=1.
REQ-019 A BAUD_W-bit bit-time counter and a 4-bit bit counter (0..10) SHALL advance the frame; the frame register SHALL shift right, filling with 1.
REQ-020 After the 11th bit-time completes, the block SHALL return to IDLE with tx=1 and txrdy=1 on the same clock.
REQ-021 A load on the first IDLE cycle SHALL be accepted, giving back-to-back frames with no idle gap beyond one clock.
REQ-022 Changes to k, eight, pen or ohel during SHIFT SHALL NOT affect the frame in progress, except k, which is sampled at each bit-time reload.

Reset
REQ-023 reset low SHALL immediately force: IDLE, tx=1, txrdy=1, and all counters and the frame register cleared to their idle values (frame = all 1s).
REQ-024 Deassertion SHALL be synchronized to clk externally; the block SHALL accept load on the first clock after deassertion.
REQ-025 Reset mid-frame SHALL abort the frame with no partial-bit glitch low on tx.

Configuration
REQ-026 The macro UART_TX_PARITY_EN SHALL control parity generation:
- Defined: pen and ohel behave as in REQ-015 and REQ-016.
- Undefined: pen and ohel are ignored, the parity logic is removed, and frames are built as if pen=0.

Verification
REQ-027 Scenario 1 SHALL be: reset low mid-frame -> tx=1, txrdy=1 within the same cycle; after release, load 0x55 -> normal frame.
REQ-028 Scenario 2 SHALL be: k=4, eight=1, pen=0, load 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1,1, each bit 4 clocks; txrdy high 44 clocks after load.
REQ-029 Scenario 3 SHALL be: k=3, eight=1, pen=1, ohel=0, load 0x07 -> parity bit 1; repeating with ohel=1 -> parity bit 0 (with UART_TX_PARITY_EN defined).
REQ-030 Scenario 4 SHALL be: eight=0, pen=1, ohel=0, load 0xFF -> data 1111111, parity 1, stop bits 1,1, D7 not sent.
REQ-031 Scenario 5 SHALL be: load held high continuously at k=2 -> back-to-back frames, each 22 clocks, and mid-frame loads ignored.
REQ-032 Scenario 6 SHALL be: k=0, load 0x00 -> each bit 1 clock, frame 11 clocks.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: fixed 11-bit-time UART transmitter.
//
// A frame is: start (0), D0..D6, then three trailing positions that depend on
// eight/pen: {D7, parity, 1}, {D7, 1, 1}, {parity, 1, 1} or {1, 1, 1}.
// Each bit is held max(k,1) clocks; k is re-sampled at every bit-time reload.
//
// Optional feature: define UART_TX_PARITY_EN to enable parity generation.
// When undefined, pen and ohel are ignored and frames are built as if pen=0.
//
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-low reset
//   load     - single-cycle transmit request (honoured only while txrdy=1)
//   out_port - byte to transmit
//   k        - clocks per bit time (0 behaves as 1)
//   eight    - 1 = 8 data bits, 0 = 7 data bits
//   pen      - parity enable
//   ohel     - parity select, 1 = odd, 0 = even
//   tx       - serial line, idle high
//   txrdy    - high while idle and able to accept load
module uart_tx_engine #(
  parameter int unsigned BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        out_port,
  input  logic [BAUD_W-1:0] k,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  output logic              tx,
  output logic              txrdy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [3:0] LAST_BIT = 4'd10;

  logic [0:0]        state_q, state_d;
  logic [10:0]       frame_q, frame_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;

  logic              pen_eff;
  logic              parity;
  logic [2:0]        frame_top;
  logic [10:0]       frame_load;
  logic [BAUD_W-1:0] baud_reload;

`ifdef UART_TX_PARITY_EN
  assign pen_eff = pen;
  // XOR over the transmitted data bits only; D7 contributes only in 8-bit mode.
  assign parity  = (^out_port[6:0]) ^ (eight & out_port[7]) ^ ohel;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = pen ^ ohel;
  assign pen_eff = 1'b0;
  assign parity  = 1'b1;
`endif

  // Counter counts down to zero, so a bit lasts reload+1 clocks; k=0 maps to 1 clock.
  assign baud_reload = (k == '0) ? '0 : k - {{(BAUD_W-1){1'b0}}, 1'b1};

  // Trailing frame positions, listed as {bit10, bit9, bit8}.
  always_comb begin
    frame_top = 3'b111;
    case ({eight, pen_eff})
      2'b11:   frame_top = {1'b1, parity, out_port[7]};
      2'b10:   frame_top = {1'b1, 1'b1, out_port[7]};
      2'b01:   frame_top = {1'b1, 1'b1, parity};
      default: frame_top = 3'b111;
    endcase
  end

  assign frame_load = {frame_top, out_port[6:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d    = ST_SHIFT;
          frame_d    = frame_load;
          bit_cnt_d  = 4'd0;
          baud_cnt_d = baud_reload;
        end
      end
      ST_SHIFT: begin
        if (baud_cnt_q == '0) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = ST_IDLE;
            frame_d    = '1;
            bit_cnt_d  = 4'd0;
            baud_cnt_d = '0;
          end else begin
            frame_d    = {1'b1, frame_q[10:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            baud_cnt_d = baud_reload;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d    = ST_IDLE;
        frame_d    = '1;
        bit_cnt_d  = 4'd0;
        baud_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      frame_q    <= '1;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
    end
  end

  // Frame register idles at all 1s, so tx comes straight from a flop: no glitches,
  // and reset drives it high immediately.
  assign tx    = frame_q[0];
  assign txrdy = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine: directed scenarios plus randomized traffic, all
// checked every cycle against a frame-level reference model.
module tb_uart_tx_engine;

  localparam int BW = 19;

  logic          clk;
  logic          reset;
  logic          load;
  logic [7:0]    out_port;
  logic [BW-1:0] k;
  logic          eight;
  logic          pen;
  logic          ohel;
  logic          tx;
  logic          txrdy;

  uart_tx_engine #(.BAUD_W(BW)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .out_port (out_port),
    .k        (k),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .tx       (tx),
    .txrdy    (txrdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is 11 bit slots of m_kk clocks; m_t counts clocks
  // since acceptance, so the current bit is simply m_t / m_kk.
  logic        m_busy;
  int          m_t;
  int          m_kk;
  logic [10:0] m_frame;

  function automatic logic [10:0] build_frame(input logic [7:0] d, input logic e8,
                                              input logic pe, input logic od);
    logic [10:0] f;
    logic        par;
    logic        pen_on;
    int          ones;
`ifdef UART_TX_PARITY_EN
    pen_on = pe;
`else
    pen_on = 1'b0;
`endif
    ones = $countones(d[6:0]) + ((e8 && d[7]) ? 1 : 0);
    par  = ((ones % 2) == 1) ^ od;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 7; i++) f[i+1] = d[i];
    if (e8 && pen_on) begin
      f[8] = d[7]; f[9] = par;
    end else if (e8) begin
      f[8] = d[7];
    end else if (pen_on) begin
      f[8] = par;
    end
    return f;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_t    <= 0;
    end else if (m_busy) begin
      if (m_t + 1 >= 11 * m_kk) m_busy <= 1'b0;
      m_t <= m_t + 1;
    end else if (load) begin
      m_busy  <= 1'b1;
      m_t     <= 0;
      m_kk    <= (k == '0) ? 1 : int'(k);
      m_frame <= build_frame(out_port, eight, pen, ohel);
    end
  end

  int   passed;
  int   total;
  int   sidx;
  logic smp_tx  [0:127];
  logic smp_rdy [0:127];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // Apply load for one clock edge, then at the following falling edge compare
  // the DUT against the model and record the sample.
  task automatic step(input logic ld);
    logic exp_tx;
    logic exp_rdy;
    load = ld;
    @(posedge clk);
    @(negedge clk);
    exp_rdy = !m_busy;
    exp_tx  = m_busy ? m_frame[m_t / m_kk] : 1'b1;
    chk("tx_model", {31'd0, tx}, {31'd0, exp_tx});
    chk("txrdy_model", {31'd0, txrdy}, {31'd0, exp_rdy});
    if (sidx < 128) begin
      smp_tx[sidx]  = tx;
      smp_rdy[sidx] = txrdy;
    end
    sidx++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  logic [10:0] s2_exp;
  logic        bit9_odd_exp;

  initial begin
    passed = 0; total = 0; sidx = 0;
    reset = 1'b0; load = 1'b0; out_port = 8'h00; k = '0;
    eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    #12;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_txrdy", {31'd0, txrdy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Scenario 2: 0xA5, 8N, k=4.
    k = 4; eight = 1'b1; pen = 1'b0; out_port = 8'hA5;
    s2_exp = 11'b11101001010;
    sidx = 0;
    step(1'b1);
    run(44);
    for (int b = 0; b < 11; b++) begin
      chk("s2_bit_first", {31'd0, smp_tx[4*b]}, {31'd0, s2_exp[b]});
      chk("s2_bit_last", {31'd0, smp_tx[4*b+3]}, {31'd0, s2_exp[b]});
    end
    chk("s2_rdy_43", {31'd0, smp_rdy[43]}, 32'd0);
    chk("s2_rdy_44", {31'd0, smp_rdy[44]}, 32'd1);

    // Scenario 3: 0x07, 8 data bits, parity even then odd, k=3. Bit 9 is parity.
    k = 3; eight = 1'b1; pen = 1'b1; ohel = 1'b0; out_port = 8'h07;
    sidx = 0;
    step(1'b1);
    run(33);
    chk("s3_even_par", {31'd0, smp_tx[28]}, 32'd1);
    chk("s3_rdy_33", {31'd0, smp_rdy[33]}, 32'd1);
    ohel = 1'b1;
`ifdef UART_TX_PARITY_EN
    bit9_odd_exp = 1'b0;
`else
    bit9_odd_exp = 1'b1;
`endif
    sidx = 0;
    step(1'b1);
    run(33);
    chk("s3_odd_par", {31'd0, smp_tx[28]}, {31'd0, bit9_odd_exp});

    // Scenario 4: 7 data bits, even parity, 0xFF -> start then ten 1s.
    k = 1; eight = 1'b0; pen = 1'b1; ohel = 1'b0; out_port = 8'hFF;
    sidx = 0;
    step(1'b1);
    run(11);
    chk("s4_start", {31'd0, smp_tx[0]}, 32'd0);
    for (int b = 1; b < 11; b++) chk("s4_ones", {31'd0, smp_tx[b]}, 32'd1);

    // Scenario 6: k=0 behaves as k=1, 0x00 -> 11-clock frame.
    k = 0; eight = 1'b1; pen = 1'b0; out_port = 8'h00;
    sidx = 0;
    step(1'b1);
    run(11);
    chk("s6_d7", {31'd0, smp_tx[8]}, 32'd0);
    chk("s6_stop", {31'd0, smp_tx[9]}, 32'd1);
    chk("s6_rdy_10", {31'd0, smp_rdy[10]}, 32'd0);
    chk("s6_rdy_11", {31'd0, smp_rdy[11]}, 32'd1);

    // Scenario 5: load held high at k=2 with the byte changing every clock.
    k = 2;
    sidx = 0;
    for (int i = 0; i < 70; i++) begin
      out_port = 8'($urandom);
      step(1'b1);
    end
    chk("s5_rdy_21", {31'd0, smp_rdy[21]}, 32'd0);
    chk("s5_rdy_22", {31'd0, smp_rdy[22]}, 32'd1);
    chk("s5_rdy_23", {31'd0, smp_rdy[23]}, 32'd0);
    chk("s5_rdy_45", {31'd0, smp_rdy[45]}, 32'd1);
    run(30);

    // Scenario 1: reset in the middle of a frame, then a normal 0x55 frame.
    k = 5; out_port = 8'h30; eight = 1'b1; pen = 1'b0;
    step(1'b1);
    run(7);
    #2 reset = 1'b0;
    #1;
    chk("s1_reset_tx", {31'd0, tx}, 32'd1);
    chk("s1_reset_txrdy", {31'd0, txrdy}, 32'd1);
    run(3);
    reset = 1'b1;
    out_port = 8'h55;
    sidx = 0;
    step(1'b1);
    chk("s1_accept", {31'd0, smp_rdy[0]}, 32'd0);
    run(55);

    // Randomized traffic; k only changes between frames so the model's fixed
    // slot width holds, other fields change freely.
    for (int i = 0; i < 1500; i++) begin
      if (!m_busy) k = BW'($urandom_range(0, 5));
      out_port = 8'($urandom);
      eight    = 1'($urandom);
      pen      = 1'($urandom);
      ohel     = 1'($urandom);
      step(1'($urandom));
    end
    run(70);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
